// File: rtl/arrow_pkg.sv
// ---------------------------------------------------------------------------
// arrow_pkg
//  Shared types and helpers for the arrow scheduler.
//  - dir_t / game_state_t / slot_state_t : encodings for the datapath and FSMs
//  - spawn_params_t                      : per-arrow parameters captured at spawn
//  - make_params()                       : derives spawn parameters from score/LFSR
// ---------------------------------------------------------------------------
package arrow_pkg;

    typedef enum logic [1:0] {DIR_TOP, DIR_BOTTOM, DIR_RIGHT, DIR_LEFT} dir_t;
    typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t;
    typedef enum logic [1:0] {FREE, ACTIVE, RETIRE} slot_state_t;

    localparam int MAX_SPEED = 7;
    localparam int MAX_LEVEL = 6;

    typedef struct packed {
        dir_t       direction;
        logic [2:0] speed;
        logic       inversed;
    } spawn_params_t;

    // Level is score/8 clamped to MAX_LEVEL, so speed = 1 + level never exceeds MAX_SPEED.
    // Inversed trajectories only appear from level 2 and then on 1/4 of spawns.
    function automatic spawn_params_t make_params(input logic [12:0] score_div8,
                                                  input logic [3:0]  rnd);
        spawn_params_t p;
        logic [2:0]    lvl;
        lvl         = (score_div8 > 13'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : score_div8[2:0];
        p.direction = dir_t'(rnd[1:0]);
        p.speed     = lvl + 3'd1;
        p.inversed  = (lvl >= 3'd2) & rnd[2] & rnd[3];
        return p;
    endfunction

endpackage

// File: rtl/arrow_slot_ctrl.sv
// ---------------------------------------------------------------------------
// arrow_slot_ctrl
//  One arrow slot: FREE -> ACTIVE -> RETIRE -> FREE lifecycle, age watchdog and
//  spawn parameter registers.
//  Ports:
//   clk, rst_n   clock / async active-low reset
//   frame_tick   one-cycle frame strobe
//   clr          force slot to FREE (game not in PLAY next cycle)
//   spawn        start an arrow in this slot (only honoured while FREE)
//   hit          arrow reported a hit (block or player hit)
//   params_in    parameters to capture on spawn
//   valid        arrow enable (high only while ACTIVE)
//   free/active  state flags for the scheduler
//   params_out   parameters captured at the last spawn
// ---------------------------------------------------------------------------
module arrow_slot_ctrl
    import arrow_pkg::*;
#(
    parameter int MAX_AGE = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick,
    input  logic          clr,
    input  logic          spawn,
    input  logic          hit,
    input  spawn_params_t params_in,
    output logic          valid,
    output logic          free,
    output logic          active,
    output spawn_params_t params_out
);

    slot_state_t state, state_nxt;
    logic [7:0]  age;
    logic        do_spawn;

    assign do_spawn = spawn && (state == FREE) && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FREE;
        else        state <= state_nxt;
    end

    // RETIRE holds valid low until the next frame tick so the sprite always
    // sees a fresh rising edge on reuse.
    always_comb begin
        state_nxt = state;
        case (state)
            FREE:    if (do_spawn) state_nxt = ACTIVE;
            ACTIVE:  if (hit || age == 8'(MAX_AGE)) state_nxt = RETIRE;
            RETIRE:  if (frame_tick) state_nxt = FREE;
            default: state_nxt = FREE;
        endcase
        if (clr) state_nxt = FREE;
    end

    assign valid  = (state == ACTIVE);
    assign active = (state == ACTIVE);
    assign free   = (state == FREE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age        <= '0;
            params_out <= '0;
        end else if (do_spawn) begin
            age        <= '0;
            params_out <= params_in;
        end else if (state == ACTIVE && frame_tick && age != 8'(MAX_AGE)) begin
            age <= age + 8'd1;
        end
    end

endmodule

// File: rtl/arrow_scheduler.sv
// ---------------------------------------------------------------------------
// arrow_scheduler
//  Game-level sequencer for NUM_SLOTS arrow sprites: game FSM, frame-based
//  spawn timer, lowest-free-slot spawn, score/lives bookkeeping.
//  Ports:
//   clk, rst_n            clock / async active-low reset
//   hcount_in, vcount_in  pixel position; (0,0) is the frame tick
//   start_in              start/restart (sampled in IDLE/OVER)
//   rand_in               LFSR value sampled at spawn
//   is_hit_in             per-slot hit pulse
//   hit_player_in         per-slot player-hit pulse (subset of is_hit_in)
//   slot_*_out            per-slot enable and spawn parameters
//   score_out, lives_out  game counters
//   game_over_out         high in OVER
// ---------------------------------------------------------------------------
module arrow_scheduler
    import arrow_pkg::*;
#(
    parameter int NUM_SLOTS   = 4,
    parameter int SPAWN_GAP   = 60,
    parameter int START_LIVES = 3,
    parameter int MAX_AGE     = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   start_in,
    input  logic [15:0]            rand_in,
    input  logic [NUM_SLOTS-1:0]   is_hit_in,
    input  logic [NUM_SLOTS-1:0]   hit_player_in,
    output logic [NUM_SLOTS-1:0]   slot_valid_out,
    output logic [2*NUM_SLOTS-1:0] slot_direction_out,
    output logic [3*NUM_SLOTS-1:0] slot_speed_out,
    output logic [NUM_SLOTS-1:0]   slot_inversed_out,
    output logic [15:0]            score_out,
    output logic [2:0]             lives_out,
    output logic                   game_over_out
);

    localparam int CW = $clog2(SPAWN_GAP);

    game_state_t          state, state_nxt;
    logic [CW-1:0]        cnt;
    logic                 frame_tick;
    logic                 spawn_attempt;
    logic                 slot_clr;
    logic [NUM_SLOTS-1:0] slot_free, slot_active, spawn_vec;
    logic [3:0]           blocks, misses;
    logic [16:0]          score_sum;
    logic [15:0]          score_new;
    logic [2:0]           lives_new;
    spawn_params_t        new_params;
    spawn_params_t        slot_params [NUM_SLOTS];
    logic                 unused_rand;

    assign unused_rand   = ^rand_in[15:4];
    assign frame_tick    = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign spawn_attempt = (state == PLAY) && frame_tick && (cnt == CW'(SPAWN_GAP - 1));
    assign new_params    = make_params(score_out[15:3], rand_in[3:0]);

    // ---- game FSM --------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, OVER: if (start_in) state_nxt = PLAY;
            PLAY:       if (lives_new == 3'd0) state_nxt = OVER;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        game_over_out = (state == OVER);
    end

    // Slots are held FREE whenever the game will not be in PLAY next cycle;
    // this also drops all valids on the same edge that enters OVER.
    assign slot_clr = (state_nxt != PLAY);

    // ---- lowest-index free slot wins the spawn --------------------------
    always_comb begin
        logic found;
        found     = 1'b0;
        spawn_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (spawn_attempt && slot_free[i] && !found) begin
                spawn_vec[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // ---- hit accounting (pulses on non-ACTIVE slots ignored) ------------
    always_comb begin
        blocks = '0;
        misses = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            blocks = blocks + 4'(is_hit_in[i] & ~hit_player_in[i] & slot_active[i]);
            misses = misses + 4'(hit_player_in[i] & slot_active[i]);
        end
        score_sum = {1'b0, score_out} + 17'(blocks);
        score_new = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        lives_new = (misses >= {1'b0, lives_out}) ? 3'd0 : lives_out - misses[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_out <= '0;
            lives_out <= '0;
            cnt       <= '0;
        end else if (state == PLAY) begin
            score_out <= score_new;
            lives_out <= lives_new;
            if (frame_tick) cnt <= spawn_attempt ? '0 : cnt + CW'(1);
        end else begin
            cnt <= '0;
            if (start_in) begin
                score_out <= '0;
                lives_out <= 3'(START_LIVES);
            end
        end
    end

    // ---- slot array ------------------------------------------------------
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        arrow_slot_ctrl #(.MAX_AGE(MAX_AGE)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .frame_tick (frame_tick),
            .clr        (slot_clr),
            .spawn      (spawn_vec[i]),
            .hit        (is_hit_in[i]),
            .params_in  (new_params),
            .valid      (slot_valid_out[i]),
            .free       (slot_free[i]),
            .active     (slot_active[i]),
            .params_out (slot_params[i])
        );
        assign slot_direction_out[2*i +: 2] = slot_params[i].direction;
        assign slot_speed_out[3*i +: 3]     = slot_params[i].speed;
        assign slot_inversed_out[i]         = slot_params[i].inversed;
    end

endmodule

// File: tb/tb_arrow_scheduler.sv
module tb_arrow_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        start_in;
    logic [15:0] rand_in;
    logic [3:0]  is_hit_in, hit_player_in;
    logic [3:0]  slot_valid_out, slot_inversed_out;
    logic [7:0]  slot_direction_out;
    logic [11:0] slot_speed_out;
    logic [15:0] score_out;
    logic [2:0]  lives_out;
    logic        game_over_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arrow_scheduler #(
        .NUM_SLOTS(4), .SPAWN_GAP(2), .START_LIVES(3), .MAX_AGE(255)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .hcount_in          (hcount_in),
        .vcount_in          (vcount_in),
        .start_in           (start_in),
        .rand_in            (rand_in),
        .is_hit_in          (is_hit_in),
        .hit_player_in      (hit_player_in),
        .slot_valid_out     (slot_valid_out),
        .slot_direction_out (slot_direction_out),
        .slot_speed_out     (slot_speed_out),
        .slot_inversed_out  (slot_inversed_out),
        .score_out          (score_out),
        .lives_out          (lives_out),
        .game_over_out      (game_over_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        step();
        hcount_in = 11'd1;
    endtask

    task automatic pulse(input logic [3:0] h, input logic [3:0] p);
        is_hit_in     = h;
        hit_player_in = p;
        step();
        is_hit_in     = '0;
        hit_player_in = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(slot_valid_out), 32'h0);
        chk({tag, "_dir"},   32'(slot_direction_out), 32'h0);
        chk({tag, "_speed"}, 32'(slot_speed_out), 32'h0);
        chk({tag, "_inv"},   32'(slot_inversed_out), 32'h0);
        chk({tag, "_score"}, 32'(score_out), 32'h0);
        chk({tag, "_lives"}, 32'(lives_out), 32'h0);
        chk({tag, "_over"},  32'(game_over_out), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; hcount_in = 11'd1; vcount_in = 10'd0; start_in = 1'b0;
        rand_in = '0; is_hit_in = '0; hit_player_in = '0;

        // 1: reset state, then start
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        start_in = 1'b1; step(); start_in = 1'b0;
        chk("start_lives", 32'(lives_out), 32'd3);
        chk("start_score", 32'(score_out), 32'd0);
        chk("start_valid", 32'(slot_valid_out), 32'h0);
        chk("start_over",  32'(game_over_out), 32'd0);

        // 2: first spawn after two ticks
        rand_in = 16'h0001;
        tick();
        chk("tick1_valid", 32'(slot_valid_out), 32'h0);
        tick();
        chk("spawn_valid", 32'(slot_valid_out), 32'h1);
        chk("spawn_dir",   32'(slot_direction_out[1:0]), 32'h1);
        chk("spawn_speed", 32'(slot_speed_out[2:0]), 32'd1);
        chk("spawn_inv",   32'(slot_inversed_out[0]), 32'd0);

        // 3: block on slot0, retire until tick, then reused
        pulse(4'b0001, 4'b0000);
        chk("block_score", 32'(score_out), 32'd1);
        chk("retire_valid", 32'(slot_valid_out), 32'h0);
        step();
        chk("retire_hold", 32'(slot_valid_out), 32'h0);
        tick();
        chk("free_valid", 32'(slot_valid_out), 32'h0);
        tick();
        chk("reuse_valid", 32'(slot_valid_out), 32'h1);

        // 4: lives run out
        tick(); tick();
        chk("two_active", 32'(slot_valid_out), 32'h3);
        pulse(4'b0001, 4'b0001);
        chk("miss_lives", 32'(lives_out), 32'd2);
        chk("miss_score", 32'(score_out), 32'd1);
        chk("miss_valid", 32'(slot_valid_out), 32'h2);
        tick(); tick();
        chk("refill_valid", 32'(slot_valid_out), 32'h3);
        pulse(4'b0011, 4'b0011);
        chk("dead_lives", 32'(lives_out), 32'd0);
        chk("dead_score", 32'(score_out), 32'd1);
        step();
        chk("over_flag",  32'(game_over_out), 32'd1);
        chk("over_valid", 32'(slot_valid_out), 32'h0);
        pulse(4'b0011, 4'b0000);
        chk("over_frozen", 32'(score_out), 32'd1);

        // 5: restart, reach score 16, full-pool spawn is dropped
        start_in = 1'b1; step(); start_in = 1'b0;
        chk("restart_over",  32'(game_over_out), 32'd0);
        chk("restart_lives", 32'(lives_out), 32'd3);
        chk("restart_score", 32'(score_out), 32'd0);
        rand_in = 16'h0001;
        for (int r = 0; r < 4; r++) begin
            repeat (8) tick();
            chk("round_full", 32'(slot_valid_out), 32'hF);
            pulse(4'b1111, 4'b0000);
        end
        chk("score16", 32'(score_out), 32'd16);
        rand_in = 16'h000C;
        repeat (8) tick();
        chk("l2_valid", 32'(slot_valid_out), 32'hF);
        chk("l2_speed", 32'(slot_speed_out), 32'h6DB);
        chk("l2_inv",   32'(slot_inversed_out), 32'hF);
        chk("l2_dir",   32'(slot_direction_out), 32'h00);
        rand_in = 16'h0003;
        tick(); tick();
        chk("drop_valid", 32'(slot_valid_out), 32'hF);
        chk("drop_dir",   32'(slot_direction_out), 32'h00);
        chk("drop_speed", 32'(slot_speed_out), 32'h6DB);

        // 6: age watchdog on slot0, then slot1
        pulse(4'b1111, 4'b0000);
        chk("score20", 32'(score_out), 32'd20);
        tick();
        tick();
        chk("age_spawn", 32'(slot_valid_out), 32'h1);
        repeat (254) tick();
        chk("age254", 32'(slot_valid_out), 32'hF);
        tick();
        chk("age255", 32'(slot_valid_out), 32'hF);
        step();
        chk("age_retire0", 32'(slot_valid_out), 32'hE);
        tick();
        chk("age_free0", 32'(slot_valid_out), 32'hE);
        tick();
        chk("age_hold1", 32'(slot_valid_out), 32'hE);
        step();
        chk("age_retire1", 32'(slot_valid_out), 32'hC);
        tick();
        chk("age_respawn", 32'(slot_valid_out), 32'hD);
        chk("age_resp_spd", 32'(slot_speed_out[2:0]), 32'd3);

        // async reset mid-game
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
